// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and default width for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/addsub_ripple.sv
// addsub_ripple: ripple-carry adder/subtractor; k=1 computes a-b via b^k with carry-in k.
module addsub_ripple #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         k,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0]   c;
    logic [N-1:0] bx;
    assign bx   = b ^ {N{k}};
    assign c[0] = k;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    assign cout = c[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one trial subtraction per cycle.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, d;
    logic [WIDTH-1:0] r_sh, q_sh, r_nx, q_nx;
    logic [WIDTH:0]   t;
    logic             cout, no_borrow;
    assign r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
    assign q_sh = {q[WIDTH-2:0], 1'b0};
    addsub_ripple #(.N(WIDTH + 1)) u_trial (
        .a    ({1'b0, r_sh}),
        .b    ({1'b0, d}),
        .k    (1'b1),
        .s    (t),
        .cout (cout)
    );
    // With zero-extended operands the carry-out and the clear sign bit both mean "no borrow".
    assign no_borrow = cout & ~t[WIDTH];
    assign r_nx      = no_borrow ? t[WIDTH-1:0] : r_sh;
    assign q_nx      = {q_sh[WIDTH-1:1], no_borrow};
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = start ? ((divisor != '0) ? ST_RUN : ST_DONE) : ST_IDLE;
            ST_RUN:  state_nx = (cnt == LAST) ? ST_DONE : ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            if (divisor != '0) begin
                r   <= '0;
                q   <= dividend;
                d   <= divisor;
                cnt <= '0;
            end else begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == ST_RUN) begin
            r   <= r_nx;
            q   <= q_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                quotient    <= q_nx;
                remainder   <= r_nx;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vectors and an exhaustive sweep for the 4-bit divider.
module tb_seq_restoring_divider;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 0, 1);
    endtask
    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                             input int elat, input int ebsy);
        int lat, bsy;
        launch(a, b);
        wait_done(lat, bsy);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bsy, ebsy);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int pulses, lat, bsy, last_cyc;
        logic [W-1:0] cq, cr;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        rst_n = 1'b1;
        run_check("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, 4);
        run_check("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 4);
        run_check("d3_9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 5, 4);
        run_check("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5, 4);
        run_check("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, 4);
        run_check("d7_0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1, 0);
        // A second start arriving mid-iteration must be dropped, not queued.
        launch(4'd13, 4'd3);
        pulses = 0;
        cq = '0;
        cr = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) begin
                dividend = 4'd9;
                divisor  = 4'd2;
                start    = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                pulses++;
                cq = quotient;
                cr = remainder;
            end
        end
        check("ign_pulses", pulses, 1);
        check("ign_q", 32'(cq), 4);
        check("ign_r", 32'(cr), 1);
        launch(4'd13, 4'd3);
        repeat (2) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_q", 32'(quotient), 0);
        check("abort_r", 32'(remainder), 0);
        check("abort_dbz", 32'(div_by_zero), 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_check("d12_5", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5, 4);
        // Back-to-back: start held high, operands swapped after each result.
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        last_cyc = 0;
        for (int n = 0; n < 6; n++) begin
            wait_done(lat, bsy);
            check($sformatf("b2b%0d_q", n), 32'(quotient), (n % 2 == 0) ? 4 : 3);
            check($sformatf("b2b%0d_r", n), 32'(remainder), (n % 2 == 0) ? 1 : 2);
            if (n > 0) check($sformatf("b2b%0d_period", n), cyc - last_cyc, 6);
            last_cyc = cyc;
            dividend = (n % 2 == 0) ? 4'd14 : 4'd13;
            divisor  = (n % 2 == 0) ? 4'd4 : 4'd3;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(4'(a), 4'(b));
                wait_done(lat, bsy);
                check($sformatf("sw%0d_%0d_q", a, b), 32'(quotient), (b == 0) ? 15 : a / b);
                check($sformatf("sw%0d_%0d_r", a, b), 32'(remainder), (b == 0) ? a : a % b);
                check($sformatf("sw%0d_%0d_dbz", a, b), 32'(div_by_zero), (b == 0) ? 1 : 0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
